// File: rtl/ubw_pkg.sv
// Shared types for the update bin writer: CCI-P write channel types, status-line
// layout and the controller state encoding.
package ubw_pkg;

    localparam int MAX_BINS  = 8;
    localparam int CL_ADDR_W = 42;
    localparam int CL_DATA_W = 512;

    // Status line layout is fixed at MAX_BINS so software sees one format for any NUM_BINS.
    localparam int          STATUS_MAGIC_LSB = 0;
    localparam int          STATUS_COUNT_LSB = 64;
    localparam int          STATUS_OVF_LSB   = STATUS_COUNT_LSB + 32 * MAX_BINS;
    localparam logic [63:0] STATUS_MAGIC     = 64'h1;

    typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
    typedef logic [CL_DATA_W-1:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_STATUS   = 3'd3,
        ST_WAIT_RSP = 3'd4
    } ubw_state_e;

    function automatic t_if_ccip_c1_Tx ubw_wr_line(input t_ccip_clAddr addr,
                                                   input t_ccip_clData data);
        t_if_ccip_c1_Tx tx;
        tx              = '0;
        tx.hdr.sop      = 1'b1;
        tx.hdr.vc_sel   = eVC_VA;
        tx.hdr.cl_len   = eCL_LEN_1;
        tx.hdr.req_type = eREQ_WRLINE_I;
        tx.hdr.address  = addr;
        tx.data         = data;
        tx.valid        = 1'b1;
        return tx;
    endfunction

endpackage

// File: rtl/ubw_req_fifo.sv
// Request FIFO holding {cacheline address, line data}; count is a register so the
// writer can derive a registered ready from it.
module ubw_req_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 554
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_push  = push && (count != (PTR_W + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/update_bin_writer.sv
// Streams update words into per-bin cacheline regions over the CCI-P write channel,
// then writes one status line and waits for every write response.
module update_bin_writer
    import ubw_pkg::*;
#(
    parameter int NUM_BINS   = 4,
    parameter int FIFO_DEPTH = 64,
    parameter int SKID       = 4,
    localparam int BIN_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  t_ccip_clAddr [NUM_BINS-1:0]   bin_base,
    input  logic [NUM_BINS-1:0][31:0]     bin_cap,
    input  t_ccip_clAddr                  status_addr,
    input  logic [511:0]                  in_data,
    input  logic [BIN_W-1:0]              in_bin,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          last_in,
    input  logic                          c1TxAlmFull,
    input  logic                          c1_rspValid,
    output t_if_ccip_c1_Tx                c1tx,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_BINS-1:0][31:0]     bin_count,
    output logic [NUM_BINS-1:0]           overflow,
    output ubw_state_e                    state_dbg
);

    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W        = CL_ADDR_W + CL_DATA_W;
    localparam int IN_READY_LIMIT = FIFO_DEPTH - SKID;

    ubw_state_e                  state;
    ubw_state_e                  state_nxt;
    t_ccip_clAddr [NUM_BINS-1:0] base_q;
    logic [NUM_BINS-1:0][31:0]   cap_q;
    t_ccip_clAddr                status_addr_q;
    logic [NUM_BINS-1:0][31:0]   bin_count_q;
    logic [NUM_BINS-1:0]         overflow_q;
    logic [31:0]                 req_cnt;
    logic [31:0]                 rsp_cnt;
    logic [31:0]                 req_nxt;
    logic [31:0]                 rsp_nxt;
    logic                        in_ready_q;
    logic                        done_q;
    logic                        done_set;
    t_if_ccip_c1_Tx              c1tx_q;

    logic                        start_go;
    logic                        accept;
    logic                        bin_ok;
    logic                        has_room;
    logic                        push;
    logic                        ovf_set;
    logic                        pop;
    logic [ENTRY_W-1:0]          push_data;
    logic [ENTRY_W-1:0]          pop_data;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_empty;
    int                          occ_nxt;
    t_ccip_clData                status_data;

    assign start_go  = (state == ST_IDLE) && start;
    assign accept    = in_valid && in_ready_q;
    assign bin_ok    = int'(in_bin) < NUM_BINS;
    assign has_room  = bin_count_q[in_bin] < cap_q[in_bin];
    assign push      = accept && bin_ok && has_room;
    assign ovf_set   = accept && bin_ok && !has_room;
    assign push_data = {base_q[in_bin] + t_ccip_clAddr'(bin_count_q[in_bin]), in_data};
    assign pop       = ((state == ST_RUN) || (state == ST_DRAIN)) && !fifo_empty && !c1TxAlmFull;
    assign occ_nxt   = int'(fifo_count) + int'(push) - int'(pop);
    assign req_nxt   = req_cnt + (c1tx_q.valid ? 32'd1 : 32'd0);
    assign rsp_nxt   = rsp_cnt + (((state != ST_IDLE) && c1_rspValid) ? 32'd1 : 32'd0);

    ubw_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A last_in that arrives with an unaccepted word waits for that word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_RUN;
            ST_RUN:      if (last_in && (!in_valid || in_ready_q)) state_nxt = ST_DRAIN;
            ST_DRAIN:    if (fifo_empty) state_nxt = ST_STATUS;
            ST_STATUS:   state_nxt = ST_WAIT_RSP;
            ST_WAIT_RSP: if (req_nxt == rsp_nxt) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done_set  = (state == ST_WAIT_RSP) && (state_nxt == ST_IDLE);
        state_dbg = state;
    end

    always_comb begin
        status_data = '0;
        status_data[STATUS_MAGIC_LSB +: 64] = STATUS_MAGIC;
        for (int i = 0; i < NUM_BINS; i++) begin
            status_data[STATUS_COUNT_LSB + 32 * i +: 32] = bin_count_q[i];
        end
        status_data[STATUS_OVF_LSB +: 64] = 64'(overflow_q);
    end

    always_ff @(posedge clk) begin
        if (start_go) begin
            base_q        <= bin_base;
            cap_q         <= bin_cap;
            status_addr_q <= status_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start_go) begin
            bin_count_q <= '0;
            overflow_q  <= '0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
        end else begin
            req_cnt <= req_nxt;
            rsp_cnt <= rsp_nxt;
            if (push) begin
                bin_count_q[in_bin] <= bin_count_q[in_bin] + 32'd1;
            end
            if (ovf_set) begin
                overflow_q[in_bin] <= 1'b1;
            end
        end
    end

    // Status write ignores almost-full: it is a single line after the data has drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            c1tx_q <= '0;
        end else if (state == ST_STATUS) begin
            c1tx_q <= ubw_wr_line(status_addr_q, status_data);
        end else if (pop) begin
            c1tx_q <= ubw_wr_line(pop_data[ENTRY_W-1 -: CL_ADDR_W], pop_data[CL_DATA_W-1:0]);
        end else begin
            c1tx_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt == ST_RUN) && (occ_nxt < IN_READY_LIMIT);
            done_q     <= done_set;
        end
    end

    assign in_ready  = in_ready_q;
    assign done      = done_q;
    assign c1tx      = c1tx_q;
    assign bin_count = bin_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_update_bin_writer.sv
// Directed bench for update_bin_writer: per-bin addressing, overflow, back-pressure,
// reset during response wait and start-while-busy.
module tb_update_bin_writer;
    import ubw_pkg::*;

    localparam int NB    = 4;
    localparam int EXP_W = CL_ADDR_W + CL_DATA_W;

    logic                    clk;
    logic                    reset;
    logic                    start;
    t_ccip_clAddr [NB-1:0]   bin_base;
    logic [NB-1:0][31:0]     bin_cap;
    t_ccip_clAddr            status_addr;
    logic [511:0]            in_data;
    logic [1:0]              in_bin;
    logic                    in_valid;
    logic                    in_ready;
    logic                    last_in;
    logic                    c1TxAlmFull;
    logic                    c1_rspValid;
    t_if_ccip_c1_Tx          c1tx;
    logic                    busy;
    logic                    done;
    logic [NB-1:0][31:0]     bin_count;
    logic [NB-1:0]           overflow;
    ubw_state_e              state_dbg;

    update_bin_writer #(
        .NUM_BINS   (NB),
        .FIFO_DEPTH (64),
        .SKID       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bin_base    (bin_base),
        .bin_cap     (bin_cap),
        .status_addr (status_addr),
        .in_data     (in_data),
        .in_bin      (in_bin),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .last_in     (last_in),
        .c1TxAlmFull (c1TxAlmFull),
        .c1_rspValid (c1_rspValid),
        .c1tx        (c1tx),
        .busy        (busy),
        .done        (done),
        .bin_count   (bin_count),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 n_wr  = 0;
    int                 n_acc = 0;
    logic [EXP_W-1:0]   exp_q[$];
    logic [31:0]        m_cnt[NB];
    logic [31:0]        m_cap[NB];
    t_ccip_clAddr       m_base[NB];
    t_ccip_clAddr       m_status;
    logic [NB-1:0]      m_ovf;
    logic [EXP_W-1:0]   mon_e;
    t_ccip_c1_ReqMemHdr mon_h;

    task automatic check_val(input string tag, input logic [599:0] got, input logic [599:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (c1tx.valid) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check_val("wr_queue_nonempty", 600'(exp_q.size()), 600'(1));
            end else begin
                mon_e          = exp_q.pop_front();
                mon_h          = '0;
                mon_h.sop      = 1'b1;
                mon_h.vc_sel   = eVC_VA;
                mon_h.cl_len   = eCL_LEN_1;
                mon_h.req_type = eREQ_WRLINE_I;
                mon_h.address  = mon_e[EXP_W-1 -: CL_ADDR_W];
                check_val("wr_addr", 600'(c1tx.hdr.address), 600'(mon_h.address));
                check_val("wr_hdr", 600'(c1tx.hdr), 600'(mon_h));
                check_val("wr_data", 600'(c1tx.data), 600'(mon_e[CL_DATA_W-1:0]));
            end
        end else begin
            check_val("c1tx_idle_zero", 600'(c1tx), 600'(0));
        end
    end

    always @(posedge clk) begin
        if (!reset && in_valid && in_ready) n_acc++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_status_exp();
        logic [511:0] sd;
        sd        = '0;
        sd[63:0]  = 64'h1;
        for (int i = 0; i < NB; i++) sd[64 + 32 * i +: 32] = m_cnt[i];
        sd[320 +: NB] = m_ovf;
        exp_q.push_back({m_status, sd});
    endtask

    task automatic start_run();
        for (int i = 0; i < NB; i++) begin
            bin_base[i] = m_base[i];
            bin_cap[i]  = m_cap[i];
            m_cnt[i]    = 32'd0;
        end
        m_ovf       = '0;
        status_addr = m_status;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic send_word(input int bin, input logic [511:0] d, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_bin   = bin[1:0];
        in_data  = d;
        last_in  = last;
        while (!in_ready && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) check_val("in_ready_timeout", 600'(in_ready), 600'(1));
        if (m_cnt[bin] < m_cap[bin]) begin
            exp_q.push_back({m_base[bin] + t_ccip_clAddr'(m_cnt[bin]), d});
            m_cnt[bin] = m_cnt[bin] + 32'd1;
        end else begin
            m_ovf[bin] = 1'b1;
        end
        if (last) push_status_exp();
        tick();
        in_valid = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int guard;
        guard = 0;
        while (n_wr < target && guard < 300) begin
            tick();
            guard++;
        end
        tick();
        check_val("writes_seen", 600'(n_wr), 600'(target));
    endtask

    task automatic send_rsp(input int n);
        repeat (n) begin
            c1_rspValid = 1'b1;
            tick();
        end
        c1_rspValid = 1'b0;
    endtask

    task automatic wait_done();
        int   guard;
        logic seen;
        guard = 0;
        seen  = 1'b0;
        while (!seen && guard < 20) begin
            if (done) seen = 1'b1;
            else begin
                tick();
                guard++;
            end
        end
        check_val("done_pulse", 600'(seen), 600'(1));
        check_val("idle_after_done", 600'(busy), 600'(0));
        tick();
        check_val("done_one_cycle", 600'(done), 600'(0));
    endtask

    int   wr0;
    int   acc0;
    int   nv;
    int   acc_drop;
    logic drop_seen;

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        bin_base    = '0;
        bin_cap     = '0;
        status_addr = '0;
        in_data     = '0;
        in_bin      = '0;
        in_valid    = 1'b0;
        last_in     = 1'b0;
        c1TxAlmFull = 1'b0;
        c1_rspValid = 1'b0;
        m_base      = '{42'h800, 42'hC00, 42'h1000, 42'h1400};
        m_status    = 42'h2000;
        m_ovf       = '0;
        for (int i = 0; i < NB; i++) begin
            m_cnt[i] = 32'd0;
            m_cap[i] = 32'd8;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        check_val("rst_state", 600'(state_dbg), 600'(ST_IDLE));
        check_val("rst_in_ready", 600'(in_ready), 600'(0));
        check_val("rst_busy", 600'(busy), 600'(0));
        check_val("rst_done", 600'(done), 600'(0));
        check_val("rst_bin_count", 600'(bin_count), 600'(0));
        check_val("rst_overflow", 600'(overflow), 600'(0));

        // three words to bin 2, last on the third
        wr0 = n_wr;
        start_run();
        check_val("run_busy", 600'(busy), 600'(1));
        check_val("run_in_ready", 600'(in_ready), 600'(1));
        send_word(2, 512'h11, 1'b0);
        send_word(2, 512'h22, 1'b0);
        send_word(2, 512'h33, 1'b1);
        wait_writes(wr0 + 4);
        check_val("t1_wait_state", 600'(state_dbg), 600'(ST_WAIT_RSP));
        check_val("t1_bin_count", 600'(bin_count), 600'({32'd0, 32'd3, 32'd0, 32'd0}));
        check_val("t1_overflow", 600'(overflow), 600'(0));
        check_val("t1_no_early_done", 600'(done), 600'(0));
        send_rsp(4);
        wait_done();

        // cap 2 on bin 0, five words
        m_cap[0] = 32'd2;
        wr0 = n_wr;
        start_run();
        for (int i = 0; i < 5; i++) send_word(0, 512'(32'hB000 + i), i == 4);
        wait_writes(wr0 + 3);
        check_val("t2_overflow", 600'(overflow), 600'(4'b0001));
        check_val("t2_bin_count0", 600'(bin_count[0]), 600'(2));
        send_rsp(3);
        wait_done();

        // almost-full held for 100 cycles during a 70-word burst
        for (int i = 0; i < NB; i++) m_cap[i] = 32'd100;
        wr0 = n_wr;
        start_run();
        c1TxAlmFull = 1'b1;
        acc0 = n_acc;
        nv = 0;
        drop_seen = 1'b0;
        acc_drop = 0;
        fork
            begin
                for (int i = 0; i < 70; i++) send_word(i % 4, 512'(32'hC000 + i), i == 69);
            end
            begin
                repeat (100) begin
                    @(negedge clk);
                    if (c1tx.valid) nv++;
                    if (!in_ready && !drop_seen) begin
                        drop_seen = 1'b1;
                        acc_drop  = n_acc - acc0;
                    end
                end
                check_val("t3_no_valid_almfull", 600'(nv), 600'(0));
                check_val("t3_ready_dropped", 600'(drop_seen), 600'(1));
                check_val("t3_drop_occupancy", 600'(acc_drop), 600'(60));
                check_val("t3_accepted_held", 600'(n_acc - acc0), 600'(60));
                c1TxAlmFull = 1'b0;
            end
        join
        wait_writes(wr0 + 71);
        check_val("t3_bin_count", 600'(bin_count), 600'({32'd17, 32'd17, 32'd18, 32'd18}));
        send_rsp(71);
        wait_done();

        // reset while waiting on three responses
        for (int i = 0; i < NB; i++) m_cap[i] = 32'd8;
        wr0 = n_wr;
        start_run();
        send_word(3, 512'hD1, 1'b0);
        send_word(3, 512'hD2, 1'b1);
        wait_writes(wr0 + 3);
        check_val("t4_wait_state", 600'(state_dbg), 600'(ST_WAIT_RSP));
        reset = 1'b1;
        tick();
        check_val("t4_reset_idle", 600'(state_dbg), 600'(ST_IDLE));
        check_val("t4_reset_busy", 600'(busy), 600'(0));
        check_val("t4_reset_count", 600'(bin_count), 600'(0));
        reset = 1'b0;
        check_val("t4_queue_empty", 600'(exp_q.size()), 600'(0));
        send_rsp(3);
        check_val("t4_late_rsp_idle", 600'(state_dbg), 600'(ST_IDLE));
        check_val("t4_late_rsp_done", 600'(done), 600'(0));
        wr0 = n_wr;
        start_run();
        send_word(1, 512'hE1, 1'b1);
        wait_writes(wr0 + 2);
        send_rsp(1);
        tick();
        check_val("t4_one_rsp_pending", 600'(state_dbg), 600'(ST_WAIT_RSP));
        check_val("t4_one_rsp_no_done", 600'(done), 600'(0));
        send_rsp(1);
        check_val("t4_bin_count1", 600'(bin_count[1]), 600'(1));
        wait_done();

        // start pulsed mid-run with different config on the inputs
        wr0 = n_wr;
        start_run();
        send_word(0, 512'hF1, 1'b0);
        send_word(0, 512'hF2, 1'b0);
        for (int i = 0; i < NB; i++) bin_base[i] = 42'h7000;
        status_addr = 42'h7777;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("t5_still_run", 600'(state_dbg), 600'(ST_RUN));
        check_val("t5_count_kept", 600'(bin_count[0]), 600'(2));
        send_word(0, 512'hF3, 1'b1);
        wait_writes(wr0 + 4);
        check_val("t5_bin_count0", 600'(bin_count[0]), 600'(3));
        send_rsp(4);
        wait_done();

        check_val("scoreboard_drained", 600'(exp_q.size()), 600'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/update_bin_writer.md
UPDATE_BIN_WRITER -- requirements
Module: update_bin_writer

Interface
REQ-001 SHALL have parameter NUM_BINS, default 4; number of update bins, legal range 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 64; request FIFO depth, power of two.
REQ-003 SHALL have parameter SKID, default 4; free FIFO slots kept in reserve when in_ready deasserts.
REQ-004 SHALL have port clk  input  1  single clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that latches config and begins a run.
REQ-007 SHALL have port bin_base  input  NUM_BINS x t_ccip_clAddr  per-bin base cacheline address.
REQ-008 SHALL have port bin_cap  input  NUM_BINS x 32  per-bin capacity, in cachelines.
REQ-009 SHALL have port status_addr  input  t_ccip_clAddr  cacheline address of the status line.
REQ-010 SHALL have port in_data  input  512  update word.
REQ-011 SHALL have port in_bin  input  $clog2(NUM_BINS) (min 1)  target bin of the update word.
REQ-012 SHALL have port in_valid  input  1  in_data/in_bin qualifier.
REQ-013 SHALL have port in_ready  output  1  word accepted when in_valid & in_ready.
REQ-014 SHALL have port last_in  input  1  end of input stream.
REQ-015 SHALL have port c1TxAlmFull  input  1  CCI-P write channel almost-full.
REQ-016 SHALL have port c1_rspValid  input  1  one write response received.
REQ-017 SHALL have port c1tx  output  t_if_ccip_c1_Tx  write request.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle pulse when the run completes.
REQ-020 SHALL have port bin_count  output  NUM_BINS x 32  lines written per bin.
REQ-021 SHALL have port overflow  output  NUM_BINS  per-bin sticky overflow flag.

Function
REQ-022 FSM states: IDLE -> RUN on start; RUN -> DRAIN on last_in; DRAIN -> STATUS when the FIFO is empty and no request is in flight in the issue stage; STATUS -> WAIT_RSP after one cycle; WAIT_RSP -> IDLE when the response count equals the request count, pulsing done.
REQ-023 start in IDLE latches bin_base, bin_cap and status_addr, and clears bin_count, overflow and both request/response counters; start outside IDLE is ignored.
REQ-024 in_ready is a registered signal, asserted only in RUN while FIFO occupancy < FIFO_DEPTH-SKID.
REQ-025 An accepted word whose bin has bin_count < bin_cap is pushed with address bin_base[bin]+bin_count[bin] (modulo address width), and that bin_count increments in the same cycle.
REQ-026 An accepted word whose bin has bin_count == bin_cap is dropped, sets overflow[bin], and leaves bin_count unchanged.
REQ-027 in_valid & in_ready & last_in in the same cycle accepts that word first, then enters DRAIN.
REQ-028 Issue stage pops the FIFO when it is non-empty and c1TxAlmFull is low; c1tx.valid is asserted exactly one cycle after the pop, and no pop occurs while c1TxAlmFull is high.
REQ-029 c1tx.hdr fields: sop=1, vc_sel=eVC_VA, cl_len=eCL_LEN_1, req_type=eREQ_WRLINE_I, mdata=0, reserved fields 0; c1tx is all-zero when not valid.
REQ-030 STATUS issues one write to status_addr with data {overflow zero-extended to 64b, bin_count[NUM_BINS-1..0] packed 32b each from bit 64 upward, 64'h1 in bits 63:0}, remaining bits 0; this write is issued even while c1TxAlmFull is high.
REQ-031 Request counter increments on every c1tx.valid; response counter increments on c1_rspValid in any non-IDLE state; responses in IDLE are ignored.
REQ-032 Counters are 32 bits; no saturation is required within bin_cap limits.

Reset
REQ-033 On reset: state IDLE, in_ready 0, c1tx 0, busy 0, done 0, bin_count 0, overflow 0, counters 0, FIFO emptied.
REQ-034 Reset mid-run abandons all in-flight requests and responses without a status write; behaviour is identical to reset from IDLE.

Structure
REQ-035 Package ubw_pkg holds MAX_BINS=8, the status-line field offsets and the FSM state enum.
REQ-036 Request FIFO SHALL be one sub-module, ubw_req_fifo (address+512b data, registered count output).

Verification
REQ-037 NUM_BINS=4, caps 8, 3 words to bin 2 with base 0x1000, then last_in -> writes to 0x1000..0x1002, then a status write with bin_count[2]=3, 4 responses, done pulse.
REQ-038 Cap 2 on bin 0, 5 words to bin 0 -> exactly 2 writes, overflow=4'b0001, status overflow field =1.
REQ-039 c1TxAlmFull held high for 100 cycles during a 70-word burst -> no c1tx.valid, in_ready drops at occupancy 60, no word lost.
REQ-040 in_valid+last_in in the same cycle -> that word is written before the status line.
REQ-041 Reset asserted in WAIT_RSP with 3 responses outstanding -> IDLE next cycle; late rspValid ignored; next run counts from 0.
REQ-042 start pulsed during RUN -> ignored; counts and addresses unchanged.
